oddr_ds_burst: RTL and testbench
================================

// Module: oddr_ds_burst
// PURPOSE
//  Parametrised multi-lane DDR differential output driver with burst framing.
//  - Buffers 2-bit-per-lane words in a small FIFO; frames each burst with preamble/postamble (DQS/CK style).
//  - Drives WIDTH lanes of ODDR+OBUFDS.
//  - Used by the PHY for DQS/clock-like differential strobes and differential data groups that need gap-free bursts.
// PARAMETERS
//  WIDTH        1                number of differential lanes (1..16)
//  DEPTH        4                FIFO depth in words, power of 2 (2..16)
//  PREAMBLE     1                preamble length in clk cycles (0..7)
//  POSTAMBLE    1                postamble length in clk cycles (0..7)
//  IDLE_VAL     2'b00            {D2,D1} driven per lane in IDLE/PRE/POST and on underrun
//  IOSTANDARD   "DIFF_SSTL15"    OBUFDS I/O standard
//  SLEW         "SLOW"           OBUFDS slew
//  DDR_CLK_EDGE "OPPOSITE_EDGE"  ODDR clock-edge mode
// PORTS
//  clk        in   1                 single clock; all logic on rising edge
//  rst        in   1                 reset, synchronous, active-high
//  din        in   2*WIDTH           lane i: din[2i]=D1 (rising half), din[2i+1]=D2 (falling half)
//  din_last   in   1                 marks final word of a burst
//  din_valid  in   1                 word present
//  din_ready  out  1                 FIFO can accept; push = din_valid & din_ready
//  busy       out  1                 FSM not in IDLE
//  level      out  clog2(DEPTH)+1    FIFO occupancy
//  underrun   out  1                 one-cycle pulse: BURST needed a word, FIFO empty
//  dq         out  WIDTH             differential output, positive leg
//  ndq        out  WIDTH             differential output, negative leg
// BEHAVIOUR
//  Reset (rst=1 at an edge):
//   - FIFO flushed, level=0, din_ready=0 while rst=1, busy=0, underrun=0, FSM=IDLE.
//   - d_reg=IDLE_VAL on all lanes; ODDR R=rst (SRTYPE "SYNC") so dq=0, ndq=1.
//   - Reset mid-burst aborts immediately; no postamble.
//  FIFO:
//   - Entry = {din_last, din}. din_ready = !rst & (level<DEPTH).
//   - Push and pop in the same cycle: level unchanged. Push at full is impossible (ready=0).
//   - Pointers wrap modulo DEPTH.
//  FSM states IDLE, PRE, BURST, POST; cnt is 3 bits:
//   - IDLE:  level!=0 -> PRE with cnt=PREAMBLE-1, or -> BURST directly if PREAMBLE=0.
//   - PRE:   drive IDLE_VAL; cnt==0 -> BURST, else cnt--.
//   - BURST: level!=0 -> pop one word per cycle, d_reg=word data.
//            Popped word has last=1 -> POST with cnt=POSTAMBLE-1, or -> IDLE if POSTAMBLE=0.
//            level==0 -> d_reg=IDLE_VAL, underrun=1 that cycle, stay in BURST.
//   - POST:  drive IDLE_VAL; cnt==0 -> IDLE, else cnt--.
//   - A new burst may sit in the FIFO during POST; it starts from IDLE (min one IDLE cycle between bursts).
//  Datapath:
//   - d_reg is loaded at the pop edge; ODDR D1/D2 = d_reg lane bits, CE=1.
//   - D1 appears on dq at the next rising edge, D2 at the following falling edge.
//  Latency:
//   - Push into an empty FIFO in IDLE at edge N -> IDLE sees level at N+1 -> BURST entered at N+1+PREAMBLE.
//   - First pop happens at edge N+2+PREAMBLE; data reaches the pin one edge later.
//  Arithmetic:
//   - level is computed at full width with no overflow.
//   - cnt compare is on 3 bits; PREAMBLE/POSTAMBLE > 7 is illegal (elaboration $error).
//  Outputs: busy = (state!=IDLE); dq/ndq always complementary.
// TESTING
//  1) WIDTH=2, PREAMBLE=1, POSTAMBLE=1: push 4'hA, 4'h5, 4'h3 (last on 4'h3) back-to-back.
//     -> IDLE_VAL for 1 cycle, then 3 gap-free data cycles, then 1 postamble cycle, then busy=0.
//     -> Lane0 pin pattern: 0,1 | 1,0 | 1,1.
//  2) Fill DEPTH=4 with no pop (hold FSM via rst release timing) -> level=4, din_ready=0.
//     -> A 5th push attempt is ignored; level stays 4.
//  3) Push 1 word without last, then stall.
//     -> In BURST with an empty FIFO: underrun pulses every cycle, dq=IDLE_VAL.
//     -> A later push with last: that word goes out, then postamble.
//  4) Assert rst for 1 cycle mid-burst with 3 words queued.
//     -> Next cycle: level=0, busy=0, underrun=0; dq=0, ndq=1; no postamble.
//  5) PREAMBLE=0, POSTAMBLE=0: two 1-word bursts pushed back-to-back.
//     -> Each word is driven exactly 1 cycle, separated by exactly 1 IDLE cycle.
//  6) Simultaneous push and pop at level=2 during BURST -> level stays 2; order preserved (FIFO).

Source files
------------

// File: rtl/oddr_ds_burst.sv
// oddr_ds_burst
// Multi-lane DDR differential output driver with burst framing.
// Words of 2 bits per lane are buffered in a small FIFO. A four-state
// sequencer (IDLE, PRE, BURST, POST) wraps each burst in a preamble and a
// postamble of IDLE_VAL, and pops one word per cycle while in BURST.
// The ODDR (OPPOSITE_EDGE) and OBUFDS stages are modelled behaviourally:
// D1 drives the high half of the following cycle and D2 the low half.
module oddr_ds_burst #(
  parameter int          WIDTH        = 1,
  parameter int          DEPTH        = 4,
  parameter int          PREAMBLE     = 1,
  parameter int          POSTAMBLE    = 1,
  parameter logic [1:0]  IDLE_VAL     = 2'b00,
  parameter string       IOSTANDARD   = "DIFF_SSTL15",
  parameter string       SLEW         = "SLOW",
  parameter string       DDR_CLK_EDGE = "OPPOSITE_EDGE"
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2*WIDTH-1:0]       din,
  input  logic                     din_last,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun,
  output logic [WIDTH-1:0]         dq,
  output logic [WIDTH-1:0]         ndq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = 2 * WIDTH + 1;

  // Counter reload values; a zero-length amble never loads the counter.
  localparam logic [2:0] PRE_INIT  = (PREAMBLE  > 0) ? 3'(PREAMBLE  - 1) : 3'd0;
  localparam logic [2:0] POST_INIT = (POSTAMBLE > 0) ? 3'(POSTAMBLE - 1) : 3'd0;

  // Elaboration-time parameter legality.
  if (WIDTH < 1 || WIDTH > 16) begin : g_badWidth
    $error("oddr_ds_burst: WIDTH must be 1..16");
  end
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_badDepth
    $error("oddr_ds_burst: DEPTH must be a power of two in 2..16");
  end
  if (PREAMBLE < 0 || PREAMBLE > 7) begin : g_badPre
    $error("oddr_ds_burst: PREAMBLE must be 0..7");
  end
  if (POSTAMBLE < 0 || POSTAMBLE > 7) begin : g_badPost
    $error("oddr_ds_burst: POSTAMBLE must be 0..7");
  end
  if (DDR_CLK_EDGE != "OPPOSITE_EDGE") begin : g_badEdge
    $error("oddr_ds_burst: only OPPOSITE_EDGE output timing is modelled");
  end
  if (SLEW != "SLOW" && SLEW != "FAST") begin : g_badSlew
    $error("oddr_ds_burst: SLEW must be SLOW or FAST");
  end
  if (IOSTANDARD == "") begin : g_badIoStd
    $error("oddr_ds_burst: IOSTANDARD must be named");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    BURST = 2'd2,
    POST  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [ENT_W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]     wrPtr_q, rdPtr_q;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [2*WIDTH-1:0]   dReg_q, dReg_d;
  logic                 underrun_q, underrun_d;
  logic                 push, pop;
  logic [ENT_W-1:0]     headWord;
  logic [WIDTH-1:0]     d1Lanes, d2Lanes;
  logic [WIDTH-1:0]     riseQ_q, fallPend_q, fallQ_q;

  assign din_ready = !rst && (level_q < LVL_W'(DEPTH));
  assign push      = din_valid && din_ready;
  assign pop       = (state_q == BURST) && (level_q != '0);
  assign headWord  = mem_q[rdPtr_q];

  // Occupancy follows push/pop; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO storage holds {last, data}; it needs no reset because level gates reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= {din_last, din};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  // Burst sequencer: next state, amble counter, lane data and underrun flag.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dReg_d     = {WIDTH{IDLE_VAL}};
    underrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          if (PREAMBLE == 0) begin
            state_d = BURST;
          end else begin
            state_d = PRE;
            cnt_d   = PRE_INIT;
          end
        end
      end
      PRE: begin
        if (cnt_q == 3'd0) state_d = BURST;
        else               cnt_d   = cnt_q - 3'd1;
      end
      BURST: begin
        if (pop) begin
          dReg_d = headWord[2*WIDTH-1:0];
          if (headWord[ENT_W-1]) begin
            if (POSTAMBLE == 0) begin
              state_d = IDLE;
            end else begin
              state_d = POST;
              cnt_d   = POST_INIT;
            end
          end
        end else begin
          underrun_d = 1'b1;
        end
      end
      POST: begin
        if (cnt_q == 3'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers; reset aborts any burst without a postamble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      dReg_q     <= {WIDTH{IDLE_VAL}};
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dReg_q     <= dReg_d;
      underrun_q <= underrun_d;
    end
  end

  // Split the held word into per-lane rising-half and falling-half bits.
  always_comb begin
    d1Lanes = '0;
    d2Lanes = '0;
    for (int i = 0; i < WIDTH; i++) begin
      d1Lanes[i] = dReg_q[2*i];
      d2Lanes[i] = dReg_q[2*i+1];
    end
  end

  // ODDR rising-edge capture of both halves with synchronous reset to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      riseQ_q    <= '0;
      fallPend_q <= '0;
    end else begin
      riseQ_q    <= d1Lanes;
      fallPend_q <= d2Lanes;
    end
  end

  // ODDR opposite-edge stage: the D2 half is launched on the falling edge.
  always_ff @(negedge clk) begin
    fallQ_q <= fallPend_q;
  end

  assign dq       = clk ? riseQ_q : fallQ_q;
  assign ndq      = ~dq;
  assign busy     = (state_q != IDLE);
  assign level    = level_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_oddr_ds_burst.sv
// tb_oddr_ds_burst
// Scoreboard bench for oddr_ds_burst. Three instances share the input
// stimulus and differ in preamble/postamble length. Expected per-cycle
// observations (pins in both clock halves, busy, underrun, ready, level)
// are queued when a stimulus sequence is set up and popped one per cycle.
module tb_oddr_ds_burst;

  localparam int W = 2;

  logic           clk;
  logic           rst;
  logic [2*W-1:0] din;
  logic           dinLast;
  logic           dinValid;

  logic [W-1:0]   dqW    [3];
  logic [W-1:0]   ndqW   [3];
  logic           busyW  [3];
  logic           undW   [3];
  logic           readyW [3];
  logic [2:0]     levelW [3];

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    int testId;
    int inst;
    int rise;
    int fall;
    int busy;
    int und;
    int ready;
    int level;
  } exp_t;

  exp_t expQ[$];

  oddr_ds_burst #(.WIDTH(W), .DEPTH(4), .PREAMBLE(1), .POSTAMBLE(1)) dutA (
    .clk(clk), .rst(rst), .din(din), .din_last(dinLast), .din_valid(dinValid),
    .din_ready(readyW[0]), .busy(busyW[0]), .level(levelW[0]),
    .underrun(undW[0]), .dq(dqW[0]), .ndq(ndqW[0])
  );

  oddr_ds_burst #(.WIDTH(W), .DEPTH(4), .PREAMBLE(7), .POSTAMBLE(2)) dutB (
    .clk(clk), .rst(rst), .din(din), .din_last(dinLast), .din_valid(dinValid),
    .din_ready(readyW[1]), .busy(busyW[1]), .level(levelW[1]),
    .underrun(undW[1]), .dq(dqW[1]), .ndq(ndqW[1])
  );

  oddr_ds_burst #(.WIDTH(W), .DEPTH(4), .PREAMBLE(0), .POSTAMBLE(0)) dutC (
    .clk(clk), .rst(rst), .din(din), .din_last(dinLast), .din_valid(dinValid),
    .din_ready(readyW[2]), .busy(busyW[2]), .level(levelW[2]),
    .underrun(undW[2]), .dq(dqW[2]), .ndq(ndqW[2])
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end else begin
      passCount++;
    end
  endtask

  // Queue the expected observation for one upcoming cycle.
  task automatic expectCycle(input int id, input int inst, input int rise, input int fall,
                             input int busy, input int und, input int ready, input int level);
    exp_t e;
    e.testId = id;  e.inst = inst;  e.rise = rise;   e.fall  = fall;
    e.busy   = busy; e.und = und;   e.ready = ready; e.level = level;
    expQ.push_back(e);
  endtask

  // Drive one clock cycle of inputs, sample both halves, score one expectation.
  task automatic applyStimulus(input logic rstV, input logic validV, input logic lastV,
                               input logic [2*W-1:0] dataV);
    logic [W-1:0] riseDq [3];
    logic [W-1:0] riseNdq[3];
    logic [W-1:0] fallDq [3];
    logic [W-1:0] fallNdq[3];
    logic         busyS  [3];
    logic         undS   [3];
    logic         readyS [3];
    logic [2:0]   levelS [3];
    exp_t         e;
    string        p;
    rst      = rstV;
    dinValid = validV;
    dinLast  = lastV;
    din      = dataV;
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      riseDq[i]  = dqW[i];
      riseNdq[i] = ndqW[i];
      busyS[i]   = busyW[i];
      undS[i]    = undW[i];
      readyS[i]  = readyW[i];
      levelS[i]  = levelW[i];
    end
    @(negedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      fallDq[i]  = dqW[i];
      fallNdq[i] = ndqW[i];
    end
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      p = $sformatf("test%0d.dut%0d", e.testId, e.inst);
      checkOutput({p, ".dqRise"},   32'(riseDq[e.inst]),  32'(e.rise));
      checkOutput({p, ".dqFall"},   32'(fallDq[e.inst]),  32'(e.fall));
      checkOutput({p, ".ndqRise"},  32'(riseNdq[e.inst]), 32'((~e.rise) & 3));
      checkOutput({p, ".ndqFall"},  32'(fallNdq[e.inst]), 32'((~e.fall) & 3));
      checkOutput({p, ".busy"},     32'(busyS[e.inst]),   32'(e.busy));
      checkOutput({p, ".underrun"}, 32'(undS[e.inst]),    32'(e.und));
      checkOutput({p, ".ready"},    32'(readyS[e.inst]),  32'(e.ready));
      checkOutput({p, ".level"},    32'(levelS[e.inst]),  32'(e.level));
    end
  endtask

  // Reset all instances and let them settle for one idle cycle.
  task automatic resetDuts();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  // Test sequences. Pin values per lane pair: rise = {w[2],w[0]}, fall = {w[3],w[1]}.
  initial begin
    rst      = 1'b1;
    din      = '0;
    dinLast  = 1'b0;
    dinValid = 1'b0;
    resetDuts();

    // Three-word gap-free burst with one-cycle pre- and postamble.
    expectCycle(1, 0, 0, 0, 0, 0, 1, 1);
    expectCycle(1, 0, 0, 0, 1, 0, 1, 2);
    expectCycle(1, 0, 0, 0, 1, 0, 1, 3);
    expectCycle(1, 0, 0, 0, 1, 0, 1, 2);
    expectCycle(1, 0, 0, 3, 1, 0, 1, 1);
    expectCycle(1, 0, 3, 0, 1, 0, 1, 0);
    expectCycle(1, 0, 1, 1, 0, 0, 1, 0);
    expectCycle(1, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'hA);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h5);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h3);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    resetDuts();

    // Long preamble lets the FIFO fill; the fifth push must be refused.
    expectCycle(2, 1, 0, 0, 0, 0, 1, 1);
    expectCycle(2, 1, 0, 0, 1, 0, 1, 2);
    expectCycle(2, 1, 0, 0, 1, 0, 1, 3);
    for (int i = 0; i < 6; i++) expectCycle(2, 1, 0, 0, 1, 0, 0, 4);
    expectCycle(2, 1, 0, 0, 1, 0, 1, 3);
    expectCycle(2, 1, 1, 0, 1, 0, 1, 2);
    expectCycle(2, 1, 0, 1, 1, 0, 1, 1);
    expectCycle(2, 1, 2, 0, 1, 0, 1, 0);
    expectCycle(2, 1, 0, 2, 1, 0, 1, 0);
    expectCycle(2, 1, 0, 0, 0, 0, 1, 0);
    expectCycle(2, 1, 0, 0, 0, 0, 1, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h2);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h4);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h8);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'hF);
    repeat (11) applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    resetDuts();

    // Underrun while stalled in BURST, then a late last word closes the burst.
    expectCycle(3, 0, 0, 0, 0, 0, 1, 1);
    expectCycle(3, 0, 0, 0, 1, 0, 1, 1);
    expectCycle(3, 0, 0, 0, 1, 0, 1, 1);
    expectCycle(3, 0, 0, 0, 1, 0, 1, 0);
    expectCycle(3, 0, 2, 1, 1, 1, 1, 0);
    expectCycle(3, 0, 0, 0, 1, 1, 1, 0);
    expectCycle(3, 0, 0, 0, 1, 1, 1, 0);
    expectCycle(3, 0, 0, 0, 1, 1, 1, 1);
    expectCycle(3, 0, 0, 0, 1, 0, 1, 0);
    expectCycle(3, 0, 1, 2, 0, 0, 1, 0);
    expectCycle(3, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h6);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h9);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    resetDuts();

    // Reset mid-burst with three words queued: immediate abort, no postamble.
    expectCycle(4, 0, 0, 0, 0, 0, 1, 1);
    expectCycle(4, 0, 0, 0, 1, 0, 1, 2);
    expectCycle(4, 0, 0, 0, 1, 0, 1, 3);
    expectCycle(4, 0, 0, 0, 1, 0, 1, 3);
    expectCycle(4, 0, 1, 0, 1, 0, 1, 3);
    expectCycle(4, 0, 0, 0, 0, 0, 0, 0);
    expectCycle(4, 0, 0, 0, 0, 0, 1, 0);
    expectCycle(4, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h2);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h4);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h8);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'hF);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    resetDuts();

    // Zero-length ambles: two one-word bursts separated by one IDLE cycle.
    expectCycle(5, 2, 0, 0, 0, 0, 1, 1);
    expectCycle(5, 2, 0, 0, 1, 0, 1, 2);
    expectCycle(5, 2, 0, 0, 0, 0, 1, 1);
    expectCycle(5, 2, 2, 2, 1, 0, 1, 1);
    expectCycle(5, 2, 0, 0, 0, 0, 1, 0);
    expectCycle(5, 2, 3, 1, 0, 0, 1, 0);
    expectCycle(5, 2, 0, 0, 0, 0, 1, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'hC);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h7);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    resetDuts();

    // Concurrent push and pop at level 2 keeps level and word order.
    expectCycle(6, 0, 0, 0, 0, 0, 1, 1);
    expectCycle(6, 0, 0, 0, 1, 0, 1, 2);
    expectCycle(6, 0, 0, 0, 1, 0, 1, 2);
    expectCycle(6, 0, 0, 0, 1, 0, 1, 2);
    expectCycle(6, 0, 1, 0, 1, 0, 1, 2);
    expectCycle(6, 0, 0, 1, 1, 0, 1, 1);
    expectCycle(6, 0, 2, 0, 1, 0, 1, 0);
    expectCycle(6, 0, 0, 2, 0, 0, 1, 0);
    expectCycle(6, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h2);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h4);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h8);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);

    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
